counter_checker: RTL
====================

Name: counter_checker

Overview:
- Downstream consumer of the bounded up-counter (LOW..HIGH, saturating at HIGH).
- Samples the counter value every cycle and checks that it starts at LOW, steps by exactly +1 and saturates at HIGH.
- Buffers each accepted new value in a small FIFO.
- Presents accepted values on a valid/ready stream, with done and sticky error status, for the next stage or for a bench scoreboard.

Parameters:
LOW, 8, expected first (reset) value of the counter
HIGH, 64, expected saturation value of the counter; HIGH > LOW
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
Clk_i  input  1  clock, rising edge
Reset_i  input  1  asynchronous reset, active-high
Data_i  input  32  counter value, sampled every rising edge
Ready_i  input  1  downstream ready for Data_o
Data_o  output  32  FIFO head value
Valid_o  output  1  FIFO non-empty
Done_o  output  1  high in DONE state
Err_o  output  2  00 none, 01 step violation, 10 FIFO overflow; sticky
Count_o  output  8  number of values pushed since reset; saturates at 255

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; FIFO empty; state IDLE; prev register 0.
- Assertion of Reset_i mid-operation clears everything immediately, including queued FIFO data.
- push: 1-cycle pulse, defined per state below.
- pop: Valid_o && Ready_i.
- States:
  - IDLE:
    - Data_i == LOW -> push Data_i, prev <= Data_i, go TRACK.
    - Any other value -> stay IDLE. No error; waits for the counter to come out of reset.
  - TRACK:
    - Data_i == prev+1 (32-bit compare, no wrap accepted) and Data_i <= HIGH -> push, prev <= Data_i.
    - If additionally Data_i == HIGH -> go DONE.
    - Any other Data_i -> go ERROR, Err_o <= 01, no push.
  - DONE:
    - Done_o = 1, no pushes.
    - Data_i != HIGH -> go ERROR, Err_o <= 01, Done_o drops the same edge.
  - ERROR:
    - Terminal until reset; no pushes.
    - Err_o holds its first code; a later condition never overwrites it.
    - FIFO keeps draining normally.
- FIFO and stream:
  - Overflow: push while full and no pop on the same edge -> value dropped, go ERROR, Err_o <= 10.
  - Push and pop on the same edge when full: legal; occupancy unchanged.
  - Push and pop on the same edge when empty: no bypass. The pushed value appears next cycle.
  - Latency: a value accepted at edge n is on Data_o with Valid_o = 1 from edge n through edge n+1, when the FIFO was empty.
  - Data_o is stable while Valid_o && !Ready_i.
  - Valid_o never drops without a pop, except on reset.
  - Order is preserved, first in first out.
- Count_o increments on every push; it is not affected by pop.
- Boundary cases:
  - LOW == HIGH-1: one TRACK step reaches DONE.
  - Data_i == 0xFFFFFFFF while prev == 0xFFFFFFFF cannot pass the step check.

Decomposition:
- Shared package counter_pkg:
  - state enum: IDLE, TRACK, DONE, ERROR
  - error code constants: ERR_NONE, ERR_STEP, ERR_OVFL
  - shared LOW/HIGH defaults, so counter and checker agree on bounds
- One sub-module sync_fifo:
  - parameters WIDTH, DEPTH
  - ports: push, pop, wdata, rdata, full, empty
  - same Clk_i / Reset_i style
- FSM and checks stay in counter_checker.

Test Plan:
1. Reset_i 1 for 2 cycles, then Data_i 8,9,...,64 then held at 64, Ready_i = 1 -> Data_o streams 8..64 in order; Done_o = 1 from the edge sampling 64; Count_o = 57; Err_o = 00.
2. Ready_i = 0, Data_i 8,9,10,11,12 -> first four values queued; the push of 12 when full sets Err_o = 10, state ERROR. Raise Ready_i -> drains 8,9,10,11, then Valid_o = 0.
3. Data_i 8,9,11 -> Err_o = 01 at the edge sampling 11; Count_o = 2; later Data_i values are ignored.
4. Reach DONE, then Data_i = 63 -> Done_o falls, Err_o = 01.
5. Data_i 3,5,7 then 8 -> stays IDLE with no pushes until 8; Count_o = 1 after 8.
6. Reset_i pulsed asynchronously mid-TRACK with 3 entries queued -> Valid_o = 0, Count_o = 0, Err_o = 00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the bounded up-counter and its downstream checker:
//   - state_t      : checker FSM states (IDLE, TRACK, DONE, ERROR)
//   - ERR_*        : error codes reported on Err_o
//   - LOW_DEF/HIGH_DEF/DEPTH_DEF : default bounds and FIFO depth, so the
//     counter and the checker agree on the counting range
//   - is_step      : +1 step check with no 32-bit wrap accepted
//   - sat_inc8     : saturating 8-bit increment
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [1:0]  ERR_NONE  = 2'b00;
    localparam logic [1:0]  ERR_STEP  = 2'b01;
    localparam logic [1:0]  ERR_OVFL  = 2'b10;

    localparam logic [31:0] LOW_DEF   = 32'd8;
    localparam logic [31:0] HIGH_DEF  = 32'd64;
    localparam int          DEPTH_DEF = 4;

    // The increment is done in 33 bits so prev == 0xFFFFFFFF can never be
    // followed by a wrapped 0 that looks like a legal step.
    function automatic logic is_step(input logic [31:0] prev,
                                     input logic [31:0] value,
                                     input logic [31:0] high);
        logic [32:0] next_v;
        next_v = {1'b0, prev} + 33'd1;
        return ({1'b0, value} == next_v) && (value <= high);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_checker_if.sv
// -----------------------------------------------------------------------------
// counter_checker_if
// Output stream and status bundle of counter_checker.
//   Data_o  : FIFO head value              (checker -> consumer)
//   Valid_o : FIFO non-empty               (checker -> consumer)
//   Ready_i : consumer ready for Data_o    (consumer -> checker)
//   Done_o  : checker in DONE state        (checker -> consumer)
//   Err_o   : sticky error code            (checker -> consumer)
//   Count_o : saturating push count        (checker -> consumer)
// Modport master is the checker side, slave the consumer side.
// -----------------------------------------------------------------------------
interface counter_checker_if;

    logic [31:0] Data_o;
    logic        Valid_o;
    logic        Ready_i;
    logic        Done_o;
    logic [1:0]  Err_o;
    logic [7:0]  Count_o;

    modport master (
        output Data_o,
        output Valid_o,
        output Done_o,
        output Err_o,
        output Count_o,
        input  Ready_i
    );

    modport slave (
        input  Data_o,
        input  Valid_o,
        input  Done_o,
        input  Err_o,
        input  Count_o,
        output Ready_i
    );

endinterface

// File: rtl/counter_checker_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO, registered storage, no write-to-read bypass.
//   Clk_i    : clock, rising edge
//   Reset_i  : asynchronous reset, active-high; empties FIFO and clears storage
//   push_i   : write wdata_i; ignored when full unless pop_i on the same edge
//   pop_i    : drop head entry; ignored when empty
//   wdata_i  : write data
//   rdata_o  : head entry (valid while !empty_o)
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Accept/pointer decisions; a push into a full FIFO is legal only
    // when the head leaves on the same edge.
    always_comb begin
        do_push_s = push_i && (!full_o || pop_i);
        do_pop_s  = pop_i && !empty_o;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; cleared on reset so the head reads 0 while empty after reset.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end else begin
            mem_q[wr_ptr_q[AW-1:0]] <= mem_q[wr_ptr_q[AW-1:0]];
        end
    end

endmodule

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
// Watches a bounded up-counter (LOW..HIGH, saturating at HIGH): it must come
// out of reset at LOW, step by exactly +1 and then hold HIGH. Every accepted
// new value is queued in a FIFO and offered on a valid/ready stream.
//   Clk_i   : clock, rising edge
//   Reset_i : asynchronous reset, active-high; clears FSM, status and FIFO
//   Data_i  : counter value, sampled every rising edge
//   out_if  : stream (Data_o/Valid_o/Ready_i) and status (Done_o, Err_o,
//             Count_o), see counter_checker_if
// -----------------------------------------------------------------------------
module counter_checker
    import counter_pkg::*;
#(
    parameter logic [31:0] LOW   = LOW_DEF,
    parameter logic [31:0] HIGH  = HIGH_DEF,
    parameter int          DEPTH = DEPTH_DEF
) (
    input  logic                Clk_i,
    input  logic                Reset_i,
    input  logic [31:0]         Data_i,
    counter_checker_if.master   out_if
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] prev_q;
    logic [31:0] prev_d;
    logic [1:0]  err_q;
    logic [1:0]  err_d;
    logic [7:0]  count_q;
    logic [7:0]  count_d;

    logic        push_req_s;
    logic        step_err_s;
    logic        ovfl_s;
    logic        fifo_push_s;
    logic        pop_s;
    logic        full_s;
    logic        empty_s;
    logic [31:0] rdata_s;

    assign pop_s = !empty_s && out_if.Ready_i;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk_i   (Clk_i),
        .Reset_i (Reset_i),
        .push_i  (fifo_push_s),
        .pop_i   (pop_s),
        .wdata_i (Data_i),
        .rdata_o (rdata_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // FSM next state, push decision, overflow detection and status updates.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        err_d       = err_q;
        count_d     = count_q;
        push_req_s  = 1'b0;
        step_err_s  = 1'b0;
        ovfl_s      = 1'b0;
        fifo_push_s = 1'b0;

        case (state_q)
            IDLE: begin
                // Non-LOW values are the counter still in reset: no error.
                if (Data_i == LOW) begin
                    push_req_s = 1'b1;
                end else begin
                    push_req_s = 1'b0;
                end
            end
            TRACK: begin
                if (is_step(prev_q, Data_i, HIGH)) begin
                    push_req_s = 1'b1;
                end else begin
                    step_err_s = 1'b1;
                end
            end
            DONE: begin
                if (Data_i != HIGH) begin
                    step_err_s = 1'b1;
                end else begin
                    step_err_s = 1'b0;
                end
            end
            ERROR: begin
                push_req_s = 1'b0;
            end
            default: begin
                step_err_s = 1'b1;
            end
        endcase

        // A push into a full FIFO with no pop on this edge loses the value.
        ovfl_s      = push_req_s && full_s && !pop_s;
        fifo_push_s = push_req_s && !ovfl_s;

        if (step_err_s) begin
            state_d = ERROR;
            if (err_q == ERR_NONE) begin
                err_d = ERR_STEP;
            end else begin
                err_d = err_q;
            end
        end else if (ovfl_s) begin
            state_d = ERROR;
            if (err_q == ERR_NONE) begin
                err_d = ERR_OVFL;
            end else begin
                err_d = err_q;
            end
        end else if (fifo_push_s) begin
            prev_d  = Data_i;
            count_d = sat_inc8(count_q);
            if (Data_i == HIGH) begin
                state_d = DONE;
            end else begin
                state_d = TRACK;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and status registers.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= IDLE;
            prev_q  <= 32'd0;
            err_q   <= ERR_NONE;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign out_if.Data_o  = rdata_s;
    assign out_if.Valid_o = !empty_s;
    assign out_if.Done_o  = (state_q == DONE);
    assign out_if.Err_o   = err_q;
    assign out_if.Count_o = count_q;

endmodule
